// File: rtl/interval_timer_if.sv
// Control/status bundle between the recorder control FSM and interval_timer.
interface interval_timer_if #(
   parameter int unsigned WIDTH = 28
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] period_in;
   logic             done;
   logic             busy;
   logic [WIDTH-1:0] elapsed;
   logic             tick;

   modport master (
      output start, stop, pause, mode, load, period_in,
      input  done, busy, elapsed, tick
   );

   modport slave (
      input  start, stop, pause, mode, load, period_in,
      output done, busy, elapsed, tick
   );
endinterface

// File: rtl/interval_timer.sv
// Programmable one-shot/periodic interval timer with pause, abort, retrigger
// and a prescaled sub-tick.
module interval_timer #(
   parameter int unsigned WIDTH      = 28,
   parameter int unsigned PERIOD_RST = 199_999_999,
   parameter int unsigned TICK_DIV   = 100_000
) (
   input  logic            clk,
   input  logic            rst,
   interval_timer_if.slave bus
);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic             tick_q, tick_d;
   logic             busy_q;
   logic             advance;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Priority: stop > start > terminal > pause. advance marks a counted RUN cycle.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      presc_d  = presc_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      tick_d   = 1'b0;
      advance  = 1'b0;
      period_d = bus.load ? bus.period_in : period_q;

      if (bus.stop) begin
         state_d = IDLE;
         count_d = '0;
         presc_d = '0;
      end else if (bus.start) begin
         state_d = RUN;
         count_d = '0;
         presc_d = '0;
         mode_d  = bus.mode;
      end else begin
         case (state_q)
            RUN: begin
               if (count_q >= period_q) begin
                  done_d  = 1'b1;
                  count_d = '0;
                  advance = 1'b1;
                  if (!mode_q) state_d = IDLE;
               end else if (bus.pause) begin
                  state_d = HOLD;
               end else begin
                  count_d = count_q + WIDTH'(1);
                  advance = 1'b1;
               end
            end
            HOLD: begin
               // Releasing pause counts this cycle, so HOLD time adds exactly its length.
               if (!bus.pause) begin
                  state_d = RUN;
                  count_d = count_q + WIDTH'(1);
                  advance = 1'b1;
               end
            end
            default: ;
         endcase

         if (advance) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
               presc_d = '0;
               tick_d  = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         period_q <= WIDTH'(PERIOD_RST);
         presc_q  <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
         tick_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         period_q <= period_d;
         presc_q  <= presc_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         tick_q   <= tick_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
   assign bus.elapsed = count_q;
   assign bus.tick    = tick_q;
endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with WIDTH=8, PERIOD_RST=9, TICK_DIV=4.
module tb_interval_timer;
   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   interval_timer_if #(.WIDTH(8)) bus ();

   interval_timer #(.WIDTH(8), .PERIOD_RST(9), .TICK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic exp_cyc(input string tag, input int c, input int el,
                          input bit dn, input bit bz, input bit tk);
      chk($sformatf("%s c%0d elapsed", tag, c), 32'(bus.elapsed), 32'(el));
      chk($sformatf("%s c%0d done", tag, c),    32'(bus.done),    32'(dn));
      chk($sformatf("%s c%0d busy", tag, c),    32'(bus.busy),    32'(bz));
      chk($sformatf("%s c%0d tick", tag, c),    32'(bus.tick),    32'(tk));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input bit m);
      bus.start = 1'b1;
      bus.mode  = m;
      step();
      bus.start = 1'b0;
   endtask

   task automatic halt();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      step();
   endtask

   task automatic load_period(input int p);
      bus.load      = 1'b1;
      bus.period_in = 8'(p);
      step();
      bus.load      = 1'b0;
   endtask

   initial begin
      int n;
      bit act;
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
      bus.mode = 1'b0; bus.load = 1'b0; bus.period_in = 8'd0;
      step();
      step();
      exp_cyc("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      step();
      exp_cyc("post_reset", 0, 0, 0, 0, 0);

      // one-shot, default period
      go(1'b0);
      exp_cyc("oneshot", 0, 0, 0, 1, 0);
      for (int c = 1; c <= 14; c++) begin
         step();
         exp_cyc("oneshot", c, (c <= 9) ? c : 0, c == 10, c < 10, c <= 10 && c % 4 == 0);
      end

      // periodic with stop at cycle 25
      go(1'b1);
      for (int c = 1; c <= 32; c++) begin
         bus.stop = (c == 25);
         step();
         if (c < 25) exp_cyc("periodic", c, c % 10, c % 10 == 0, 1, c % 4 == 0);
         else        exp_cyc("periodic", c, 0, 0, 0, 0);
      end
      bus.stop = 1'b0;

      // one-shot with pause sampled on cycles 3..7
      go(1'b0);
      for (int c = 1; c <= 16; c++) begin
         bus.pause = (c >= 3 && c <= 7);
         step();
         act = !(c >= 3 && c <= 7);
         n = (c <= 2) ? c : ((c <= 7) ? 2 : c - 5);
         exp_cyc("pause", c, (n <= 9) ? n : 0, n == 10, n <= 9,
                 act && n > 0 && n <= 10 && n % 4 == 0);
      end
      bus.pause = 1'b0;

      // periodic, load period 3 while elapsed shows 6
      go(1'b1);
      for (int c = 1; c <= 20; c++) begin
         bus.load      = (c == 7);
         bus.period_in = 8'd3;
         step();
         if (c <= 7) exp_cyc("load", c, c, 0, 1, c % 4 == 0);
         else        exp_cyc("load", c, (c - 8) % 4, (c - 8) % 4 == 0, 1, c % 4 == 0);
      end
      bus.load = 1'b0;
      halt();
      load_period(9);

      // one-shot retrigger at cycle 9
      go(1'b0);
      for (int c = 1; c <= 21; c++) begin
         bus.start = (c == 9);
         step();
         if (c < 9)        exp_cyc("retrig", c, c, 0, 1, c % 4 == 0);
         else if (c == 9)  exp_cyc("retrig", c, 0, 0, 1, 0);
         else if (c <= 18) exp_cyc("retrig", c, c - 9, 0, 1, (c - 9) % 4 == 0);
         else              exp_cyc("retrig", c, 0, c == 19, 0, 0);
      end
      bus.start = 1'b0;

      // stop coincident with terminal
      go(1'b0);
      for (int c = 1; c <= 12; c++) begin
         bus.stop = (c == 10);
         step();
         if (c < 10) exp_cyc("stop_term", c, c, 0, 1, c % 4 == 0);
         else        exp_cyc("stop_term", c, 0, 0, 0, 0);
      end
      bus.stop = 1'b0;

      // periodic, start coincident with terminal
      go(1'b1);
      for (int c = 1; c <= 21; c++) begin
         bus.start = (c == 10);
         step();
         if (c < 10)       exp_cyc("start_term", c, c, 0, 1, c % 4 == 0);
         else if (c == 10) exp_cyc("start_term", c, 0, 0, 1, 0);
         else if (c < 20)  exp_cyc("start_term", c, c - 10, 0, 1, (c - 10) % 4 == 0);
         else              exp_cyc("start_term", c, c - 20, c == 20, 1, 0);
      end
      bus.start = 1'b0;
      halt();

      // period 0: periodic then one-shot
      load_period(0);
      go(1'b1);
      exp_cyc("p0_per", 0, 0, 0, 1, 0);
      for (int c = 1; c <= 3; c++) begin
         step();
         exp_cyc("p0_per", c, 0, 1, 1, 0);
      end
      halt();
      go(1'b0);
      step();
      exp_cyc("p0_one", 1, 0, 1, 0, 0);
      step();
      exp_cyc("p0_one", 2, 0, 0, 0, 0);

      // reset mid-run restores default period
      load_period(12);
      go(1'b1);
      for (int c = 1; c <= 5; c++) begin
         step();
         exp_cyc("pre_rst", c, c, 0, 1, c % 4 == 0);
      end
      rst = 1'b1;
      step();
      exp_cyc("mid_rst", 6, 0, 0, 0, 0);
      rst = 1'b0;
      go(1'b0);
      for (int c = 1; c <= 11; c++) begin
         step();
         exp_cyc("after_rst", c, (c <= 9) ? c : 0, c == 10, c < 10, c <= 10 && c % 4 == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
